// File: rtl/wavelet_accelerator_core_controller.sv
// wavelet_accelerator_core_controller: sequences coefficient load, multi-level DWT reads
// and host readout addressing for the wavelet accelerator core.
module wavelet_accelerator_core_controller #(
    parameter int ADDR_WIDTH  = 9,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_core_go,
    input  logic                  i_core_init,
    input  logic                  i_core_r_addr_rst,
    input  logic [1:0]            i_core_inputs_len,
    input  logic [1:0]            i_core_dec_level,
    input  logic [4:0]            i_core_filter_size,
    input  logic                  i_host_rd_en,
    output logic                  o_core_clear_go,
    output logic                  o_core_clear_init,
    output logic                  o_core_r_data_available,
    output logic                  o_core_error,
    output logic                  o_coef_load,
    output logic [4:0]            o_coef_addr,
    output logic                  o_in_rd_en,
    output logic [ADDR_WIDTH-1:0] o_in_rd_addr,
    output logic                  o_dp_sample_valid,
    output logic [1:0]            o_dp_level,
    output logic                  o_dp_level_start,
    output logic                  o_dp_flush,
    output logic [ADDR_WIDTH-1:0] o_r_addr
);
    typedef enum logic [2:0] {IDLE, LOAD_COEF, CLR_INIT, READ, FLUSH, CLR_GO} state_t;

    state_t                r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt, r_raddr, w_raddr;
    logic [1:0]            r_k, w_k, r_len, w_len, r_lvl, w_lvl;
    logic [4:0]            r_fs, w_fs;
    logic                  r_cv, w_cv, r_err, w_err, r_avail, w_avail, r_ok, w_ok;
    logic [MEM_LATENCY-1:0] r_sv;
    logic [ADDR_WIDTH:0]   w_n;
    logic [ADDR_WIDTH-1:0] w_rd_last, w_n_last, w_coef_last, w_flush_last;
    logic                  w_no_flush;

    assign w_n          = (ADDR_WIDTH+1)'(64) << r_len;
    assign w_rd_last    = ADDR_WIDTH'((w_n >> r_k) - (ADDR_WIDTH+1)'(1));
    assign w_n_last     = ADDR_WIDTH'(w_n - (ADDR_WIDTH+1)'(1));
    assign w_coef_last  = ADDR_WIDTH'(r_fs) - ADDR_WIDTH'(1);
    assign w_flush_last = ADDR_WIDTH'(r_fs) + ADDR_WIDTH'(MEM_LATENCY) - ADDR_WIDTH'(2);
    // a single-tap filter has nothing to drain, so FLUSH is bypassed entirely
    assign w_no_flush   = r_fs <= 5'd1;

    assign o_core_error            = r_err;
    assign o_core_r_data_available = r_avail;
    assign o_r_addr                = r_raddr;
    assign o_dp_sample_valid       = r_sv[MEM_LATENCY-1];

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_k     = r_k;
        w_len   = r_len;
        w_lvl   = r_lvl;
        w_fs    = r_fs;
        w_cv    = r_cv;
        w_err   = r_err;
        w_ok    = r_ok;
        w_avail = r_avail;
        w_raddr = r_raddr;
        if (i_core_r_addr_rst)
            w_raddr = '0;
        else if (i_host_rd_en && r_avail) begin
            w_raddr = (r_raddr == w_n_last) ? '0 : r_raddr + ADDR_WIDTH'(1);
            w_avail = r_raddr != w_n_last;
        end
        case (r_state)
            IDLE: begin
                if (i_core_init) begin
                    w_fs    = i_core_filter_size;
                    w_cv    = 1'b0;
                    w_cnt   = '0;
                    w_state = (i_core_filter_size == 5'd0) ? CLR_INIT : LOAD_COEF;
                end else if (i_core_go) begin
                    if (!r_cv) begin
                        w_err   = 1'b1;
                        w_ok    = 1'b0;
                        w_state = CLR_GO;
                    end else begin
                        w_len   = i_core_inputs_len;
                        w_lvl   = i_core_dec_level;
                        w_fs    = i_core_filter_size;
                        w_avail = 1'b0;
                        w_k     = 2'd0;
                        w_cnt   = '0;
                        w_ok    = 1'b1;
                        w_state = READ;
                    end
                end
            end
            LOAD_COEF: begin
                w_cnt   = (r_cnt == w_coef_last) ? '0 : r_cnt + ADDR_WIDTH'(1);
                w_state = (r_cnt == w_coef_last) ? CLR_INIT : LOAD_COEF;
            end
            CLR_INIT: begin
                w_cv    = r_fs != 5'd0;
                w_err   = 1'b0;
                w_state = IDLE;
            end
            READ: begin
                w_cnt = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == w_rd_last) begin
                    w_cnt = '0;
                    if (!w_no_flush)
                        w_state = FLUSH;
                    else if (r_k < r_lvl)
                        w_k = r_k + 2'd1;
                    else
                        w_state = CLR_GO;
                end
            end
            FLUSH: begin
                w_cnt = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == w_flush_last) begin
                    w_cnt   = '0;
                    w_k     = (r_k < r_lvl) ? r_k + 2'd1 : r_k;
                    w_state = (r_k < r_lvl) ? READ : CLR_GO;
                end
            end
            CLR_GO: begin
                if (r_ok) begin
                    w_avail = 1'b1;
                    w_raddr = '0;
                end
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    // outputs are registered from next-state values so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_cnt             <= '0;
            r_k               <= '0;
            r_len             <= '0;
            r_lvl             <= '0;
            r_fs              <= '0;
            r_cv              <= 1'b0;
            r_err             <= 1'b0;
            r_ok              <= 1'b0;
            r_avail           <= 1'b0;
            r_raddr           <= '0;
            r_sv              <= '0;
            o_core_clear_go   <= 1'b0;
            o_core_clear_init <= 1'b0;
            o_coef_load       <= 1'b0;
            o_coef_addr       <= '0;
            o_in_rd_en        <= 1'b0;
            o_in_rd_addr      <= '0;
            o_dp_level        <= '0;
            o_dp_level_start  <= 1'b0;
            o_dp_flush        <= 1'b0;
        end else begin
            r_state           <= w_state;
            r_cnt             <= w_cnt;
            r_k               <= w_k;
            r_len             <= w_len;
            r_lvl             <= w_lvl;
            r_fs              <= w_fs;
            r_cv              <= w_cv;
            r_err             <= w_err;
            r_ok              <= w_ok;
            r_avail           <= w_avail;
            r_raddr           <= w_raddr;
            r_sv              <= MEM_LATENCY'({r_sv, o_in_rd_en});
            o_core_clear_go   <= w_state == CLR_GO;
            o_core_clear_init <= w_state == CLR_INIT;
            o_coef_load       <= w_state == LOAD_COEF;
            o_coef_addr       <= (w_state == LOAD_COEF) ? w_cnt[4:0] : 5'd0;
            o_in_rd_en        <= w_state == READ;
            o_in_rd_addr      <= (w_state == READ) ? w_cnt : '0;
            o_dp_level        <= w_k;
            o_dp_level_start  <= (w_state == READ) && (w_cnt == '0);
            o_dp_flush        <= w_state == FLUSH;
        end
    end
endmodule

// File: tb/tb_wavelet_accelerator_core_controller.sv
// tb_wavelet_accelerator_core_controller: scoreboard of expected coefficient/read strobes
// plus a readout vector table and hand-written reset/error sequences.
module tb_wavelet_accelerator_core_controller;
    localparam int AW = 9;
    localparam int ML = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_core_go = 1'b0, i_core_init = 1'b0, i_core_r_addr_rst = 1'b0, i_host_rd_en = 1'b0;
    logic [1:0]    i_core_inputs_len = '0, i_core_dec_level = '0;
    logic [4:0]    i_core_filter_size = '0;
    logic          o_core_clear_go, o_core_clear_init, o_core_r_data_available, o_core_error;
    logic          o_coef_load, o_in_rd_en, o_dp_sample_valid, o_dp_level_start, o_dp_flush;
    logic [4:0]    o_coef_addr;
    logic [AW-1:0] o_in_rd_addr, o_r_addr;
    logic [1:0]    o_dp_level;

    always #5 clk = ~clk;

    wavelet_accelerator_core_controller #(.ADDR_WIDTH(AW), .MEM_LATENCY(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_core_go(i_core_go), .i_core_init(i_core_init), .i_core_r_addr_rst(i_core_r_addr_rst),
        .i_core_inputs_len(i_core_inputs_len), .i_core_dec_level(i_core_dec_level),
        .i_core_filter_size(i_core_filter_size), .i_host_rd_en(i_host_rd_en),
        .o_core_clear_go(o_core_clear_go), .o_core_clear_init(o_core_clear_init),
        .o_core_r_data_available(o_core_r_data_available), .o_core_error(o_core_error),
        .o_coef_load(o_coef_load), .o_coef_addr(o_coef_addr), .o_in_rd_en(o_in_rd_en),
        .o_in_rd_addr(o_in_rd_addr), .o_dp_sample_valid(o_dp_sample_valid), .o_dp_level(o_dp_level),
        .o_dp_level_start(o_dp_level_start), .o_dp_flush(o_dp_flush), .o_r_addr(o_r_addr)
    );

    typedef struct {int lvl; int addr; bit start;} rd_t;
    typedef struct {bit rd; bit ar; int reps; int exp_addr; bit exp_av;} vec_t;

    rd_t  rd_q[$];
    int   coef_q[$];
    vec_t vt[8];
    int   checks = 0, errors = 0;
    int   cyc = 0, n_start = 0, n_sv = 0, n_ci = 0, n_cg = 0, n_rd = 0, n_fl = 0;
    int   t_ci = 0, t_cg = 0, t_rd = -1, frun = 0, exp_flush = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // one clock: monitor DUT outputs against the scoreboard, then model the config register
    task automatic tick();
        rd_t e;
        @(negedge clk);
        cyc++;
        if (o_coef_load) begin
            if (coef_q.size() == 0) chk("coef_q_nonempty", coef_q.size(), 1);
            else chk("coef_addr", int'(o_coef_addr), coef_q.pop_front());
        end
        if (o_in_rd_en) begin
            n_rd++;
            if (t_rd < 0) t_rd = cyc;
            if (rd_q.size() == 0) chk("rd_q_nonempty", rd_q.size(), 1);
            else begin
                e = rd_q.pop_front();
                chk("rd_lvl_addr_start",
                    (int'(o_dp_level) << 16) | (int'(o_in_rd_addr) << 1) | int'(o_dp_level_start),
                    (e.lvl << 16) | (e.addr << 1) | int'(e.start));
            end
        end
        if (o_dp_level_start) n_start++;
        if (o_dp_sample_valid) n_sv++;
        if (o_core_clear_init) begin n_ci++; t_ci = cyc; end
        if (o_core_clear_go) begin n_cg++; t_cg = cyc; end
        if (o_dp_flush) begin
            frun++;
            n_fl++;
        end else if (frun != 0) begin
            chk("flush_len", frun, exp_flush);
            frun = 0;
        end
        if (o_core_clear_init) i_core_init = 1'b0;
        if (o_core_clear_go) i_core_go = 1'b0;
    endtask

    task automatic wait_cg(input int limit, input string nm);
        int c0 = n_cg;
        for (int i = 0; i < limit && n_cg == c0; i++) tick();
        chk(nm, n_cg - c0, 1);
    endtask

    task automatic wait_ci(input int limit, input string nm);
        int c0 = n_ci;
        for (int i = 0; i < limit && n_ci == c0; i++) tick();
        chk(nm, n_ci - c0, 1);
    endtask

    task automatic push_reads(input int len, input int lvl);
        int n = 64 << len;
        for (int k = 0; k <= lvl; k++)
            for (int a = 0; a < (n >> k); a++) rd_q.push_back('{k, a, a == 0});
    endtask

    task automatic do_init(input int fs);
        for (int i = 0; i < fs; i++) coef_q.push_back(i);
        i_core_filter_size = 5'(fs);
        i_core_init = 1'b1;
        wait_ci(100, "init_clear_pulse");
        tick();
        chk("coef_q_drained", coef_q.size(), 0);
        chk("error_after_init", int'(o_core_error), 0);
        chk("init_dropped", int'(i_core_init), 0);
    endtask

    initial begin
        int s0, f0, v0, r0, cg0, ci0, c;
        vt[0] = '{0, 0, 3, 0, 1};
        vt[1] = '{1, 0, 20, 20, 1};
        vt[2] = '{0, 1, 1, 0, 1};
        vt[3] = '{1, 0, 20, 20, 1};
        vt[4] = '{1, 1, 1, 0, 1};
        vt[5] = '{1, 0, 63, 63, 1};
        vt[6] = '{1, 0, 1, 0, 0};
        vt[7] = '{1, 0, 5, 0, 0};

        repeat (3) tick();
        chk("reset_flags", int'({o_core_clear_go, o_core_clear_init, o_core_r_data_available, o_core_error,
            o_coef_load, o_in_rd_en, o_dp_sample_valid, o_dp_level_start, o_dp_flush}), 0);
        chk("reset_addrs", int'(o_in_rd_addr) + int'(o_r_addr) + int'(o_coef_addr) + int'(o_dp_level), 0);
        rst_n = 1'b1;
        tick();

        // go with no coefficients loaded
        i_core_inputs_len = 2'd0; i_core_dec_level = 2'd1; i_core_filter_size = 5'd4;
        c = cyc;
        i_core_go = 1'b1;
        wait_cg(10, "err_go_clear_pulse");
        chk("err_go_latency", t_cg - c, 1);
        chk("err_go_error_set", int'(o_core_error), 1);
        chk("err_go_no_reads", n_rd, 0);
        do_init(4);

        // two-level run, N=64
        exp_flush = 4 - 1 + ML;
        push_reads(0, 1);
        s0 = n_start; f0 = n_fl; v0 = n_sv;
        i_core_go = 1'b1;
        wait_cg(400, "run_clear_go");
        tick(); tick();
        chk("run_reads_done", rd_q.size(), 0);
        chk("run_level_starts", n_start - s0, 2);
        chk("run_flush_cycles", n_fl - f0, 2 * exp_flush);
        chk("run_sample_valid", n_sv - v0, 96);
        chk("run_available", int'(o_core_r_data_available), 1);
        chk("run_r_addr", int'(o_r_addr), 0);
        chk("run_error", int'(o_core_error), 0);

        // readout vectors
        foreach (vt[i]) begin
            i_host_rd_en = vt[i].rd;
            i_core_r_addr_rst = vt[i].ar;
            repeat (vt[i].reps) tick();
            i_host_rd_en = 1'b0;
            i_core_r_addr_rst = 1'b0;
            chk($sformatf("readout_addr_%0d", i), int'(o_r_addr), vt[i].exp_addr);
            chk($sformatf("readout_avail_%0d", i), int'(o_core_r_data_available), int'(vt[i].exp_av));
        end

        // init and go together: init sequence must finish before reads start
        exp_flush = 2 - 1 + ML;
        coef_q.push_back(0); coef_q.push_back(1);
        push_reads(0, 0);
        i_core_filter_size = 5'd2; i_core_dec_level = 2'd0;
        t_rd = -1;
        i_core_init = 1'b1; i_core_go = 1'b1;
        wait_cg(300, "initgo_clear_go");
        chk("initgo_coef_drained", coef_q.size(), 0);
        chk("initgo_reads_done", rd_q.size(), 0);
        chk("initgo_read_after_clear_init", int'(t_rd > t_ci), 1);

        // asynchronous reset in the middle of READ
        i_core_dec_level = 2'd1;
        push_reads(0, 1);
        i_core_go = 1'b1;
        for (int i = 0; i < 100 && !(o_in_rd_en && o_in_rd_addr == 9'd37); i++) tick();
        chk("reached_addr37", int'(o_in_rd_addr), 37);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_flags", int'({o_core_clear_go, o_core_clear_init, o_core_r_data_available, o_core_error,
            o_coef_load, o_in_rd_en, o_dp_sample_valid, o_dp_level_start, o_dp_flush}), 0);
        chk("rst_async_in_rd_addr", int'(o_in_rd_addr), 0);
        chk("rst_async_r_addr", int'(o_r_addr), 0);
        chk("rst_async_level", int'(o_dp_level), 0);
        rd_q.delete();
        cg0 = n_cg; ci0 = n_ci; r0 = n_rd;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_no_clear_go", n_cg - cg0, 0);
        chk("rst_no_clear_init", n_ci - ci0, 0);
        wait_cg(10, "post_rst_go_clear");
        chk("post_rst_coefs_invalid", int'(o_core_error), 1);
        chk("post_rst_no_reads", n_rd - r0, 0);

        // boundary: N=512, four levels, single tap (flush skipped)
        do_init(1);
        i_core_inputs_len = 2'd3; i_core_dec_level = 2'd3;
        push_reads(3, 3);
        s0 = n_start; f0 = n_fl; r0 = n_rd;
        i_core_go = 1'b1;
        wait_cg(1500, "big_clear_go");
        tick();
        chk("big_reads_done", rd_q.size(), 0);
        chk("big_read_count", n_rd - r0, 960);
        chk("big_level_starts", n_start - s0, 4);
        chk("big_no_flush", n_fl - f0, 0);
        chk("big_available", int'(o_core_r_data_available), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
